// File: rtl/rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_pkg                                                     |
// | Description : Shared defaults, queue entry type and one-hot helper for   |
// |               the register-file write controller.                        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 8;
    localparam int AW     = $clog2(NREG);
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } rf_entry_t;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] addr);
        logic [NREG-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wq_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_wq_fifo                                                 |
// | Description : Write-queue storage with pointers, occupancy count and an  |
// |               age-ordered view of all entries for read bypass.          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module rf_wq_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH*W-1:0]       view_data,
    output logic [DEPTH-1:0]         view_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (push && !pop)
                r_count <= r_count + CW'(1);
            else if (pop && !push)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Slot k of the view is the k-th oldest entry; pointer math wraps with DEPTH.
    for (genvar k = 0; k < DEPTH; k++) begin : g_view
        logic [PW-1:0] w_idx;
        assign w_idx                  = r_rd_ptr + PW'(k);
        assign view_data[k*W +: W]    = r_mem[w_idx];
        assign view_valid[k]          = (CW'(k) < r_count);
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_write_ctrl                                              |
// | Description : Queued register-bank write controller with one-hot drain   |
// |               stage and youngest-first read bypass.                     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module rf_write_ctrl #(
    parameter  int DATA_W = rf_pkg::DATA_W,
    parameter  int NREG   = rf_pkg::NREG,
    parameter  int DEPTH  = rf_pkg::DEPTH,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_hold,
    output logic [NREG-1:0]          en,
    output logic [DATA_W-1:0]        d_in,
    input  logic [NREG*DATA_W-1:0]   bank_q,
    input  logic [AW-1:0]            rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     busy
);

    import rf_pkg::*;

    localparam int EW = AW + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  w_push;
    logic                  w_pop;
    logic [EW-1:0]         w_head;
    logic [AW-1:0]         w_head_addr;
    logic [DATA_W-1:0]     w_head_data;
    logic [CW-1:0]         w_count;
    logic [DEPTH*EW-1:0]   w_view_data;
    logic [DEPTH-1:0]      w_view_valid;
    logic [AW-1:0]         r_drain_addr;

    // Full blocks a push even when a pop frees a slot on the same edge.
    assign wr_ready = (w_count != CW'(DEPTH));
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = (w_count != '0) && !wr_hold;

    rf_wq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (w_push),
        .push_data  ({wr_addr, wr_data}),
        .pop        (w_pop),
        .head_data  (w_head),
        .count      (w_count),
        .view_data  (w_view_data),
        .view_valid (w_view_valid)
    );

    assign w_head_addr = w_head[EW-1 -: AW];
    assign w_head_data = w_head[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en           <= '0;
            d_in         <= '0;
            r_drain_addr <= '0;
        end else if (w_pop) begin
            en           <= NREG'(1) << w_head_addr;
            d_in         <= w_head_data;
            r_drain_addr <= w_head_addr;
        end else begin
            en           <= '0;
        end
    end

    // Oldest source first so that each younger match overrides the previous one.
    always_comb begin
        rd_data = bank_q[rd_addr*DATA_W +: DATA_W];
        if ((en != '0) && (r_drain_addr == rd_addr))
            rd_data = d_in;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_view_valid[k] && (w_view_data[k*EW + DATA_W +: AW] == rd_addr))
                rd_data = w_view_data[k*EW +: DATA_W];
        end
    end

    assign pending = w_count;
    assign busy    = (w_count != '0) || (en != '0);

endmodule
`default_nettype wire

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter NREG, default 8, number of bank registers; AW = log2(NREG) = 3.
REQ-003 Parameter DEPTH, default 4, write-queue entries (power of 2, >=2).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid  input  1  write request valid.
REQ-007 wr_ready  output  1  queue can accept a request.
REQ-008 wr_addr  input  AW  destination register index.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 wr_hold  input  1  when 1, queue SHALL NOT drain to the bank.
REQ-011 en  output  NREG  one-hot write enable to the register bank.
REQ-012 d_in  output  DATA_W  write data to the register bank.
REQ-013 bank_q  input  NREG*DATA_W  bank outputs; register i at bits [i*DATA_W +: DATA_W].
REQ-014 rd_addr  input  AW  read index.
REQ-015 rd_data  output  DATA_W  read data, bypass-corrected.
REQ-016 pending  output  log2(DEPTH)+1  number of queued writes, excluding the drain stage.
REQ-017 busy  output  1  high when pending != 0 or en != 0.

Function
REQ-018 A request SHALL be accepted on an edge where wr_valid && wr_ready; wr_ready = (pending != DEPTH), with no same-cycle pass-through when full.
REQ-019 Accepted requests SHALL be queued FIFO-ordered as {addr, data} entries.
REQ-020 Drain stage (registered en/d_in): on each edge with pending != 0 and wr_hold == 0, pop the head; drive en = onehot(head addr) and d_in = head data for exactly one cycle.
REQ-021 When no pop occurs, en SHALL be all-zero on the next cycle; d_in SHALL hold its last value.
REQ-022 Latency: request accepted at edge N with the queue empty and wr_hold low -> en valid in the cycle after edge N+1 -> bank updated at edge N+2.
REQ-023 Throughput: one drain per cycle; push and pop on the same edge SHALL leave pending unchanged.
REQ-024 en SHALL never have more than one bit set.
REQ-025 wr_hold SHALL block pops only; pushes continue until full.
REQ-026 rd_data (combinational) SHALL equal the youngest pending value for rd_addr.
REQ-027 rd_data search order, youngest first: queue tail-1 back to head, then the drain stage (en != 0), then bank_q slice rd_addr.
REQ-028 A request presented on the current cycle but not yet accepted SHALL NOT be bypassed.
REQ-029 Repeated writes to the same address SHALL all be applied to the bank in order; there is no coalescing.
REQ-030 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 On reset_n low, asynchronously: queue empty, pending = 0, en = 0, d_in = 0, pointers = 0.
REQ-032 wr_ready SHALL be 1 and busy SHALL be 0 while in reset and on exit from reset.
REQ-033 Reset mid-operation SHALL discard all queued and draining writes; none reaches the bank afterwards.

Structure
REQ-034 Shared package rf_pkg SHALL hold DATA_W, NREG, AW, DEPTH defaults, the queue entry struct {addr, data}, and a onehot(addr) function.
REQ-035 One sub-module, rf_wq_fifo (DEPTH x entry storage, pointers, count, entry visibility for bypass), SHALL be instantiated inside rf_write_ctrl.

Verification
REQ-036 After reset, write (3, 0xDEADBEEF) -> en = 8'b0000_1000 and d_in = 0xDEADBEEF exactly one cycle; bank r3 = 0xDEADBEEF at edge N+2; busy then returns to 0.
REQ-037 Hold high, push 5 writes -> wr_ready falls after 4 with pending = 4; release hold -> 4 one-hot pulses in order, pending reaches 0.
REQ-038 Hold high, queue (2,0x11), (2,0x22), rd_addr = 2 -> rd_data = 0x22; rd_addr = 5 -> rd_data = bank r5.
REQ-039 Full queue with hold low, wr_valid held -> a push is accepted each edge where a pop frees space; pending never exceeds 4 and no data is lost or reordered.
REQ-040 Queue 3 writes, assert reset_n low mid-drain -> en = 0 immediately, pending = 0, bank contents after reset all 0.
REQ-041 Random 1000-request stream with a bank model -> en is always one-hot or zero, and the final bank and every rd_data sample match the reference scoreboard.
